// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier controller that time-shares one external adder.
// Optional feature: define ZERO_BYPASS_EN to finish zero-operand requests without iterating.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     q_q;
    logic [WIDTH-1:0]     m_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   product_q;
    logic                 done_q;
    logic                 busy_q;

    logic [2*WIDTH-1:0]   shift_d;
    logic                 bypass_d;

    // One iteration: take the adder result and shift {C,A,Q} right by one bit.
    assign shift_d = {add_cout, add_sum, q_q[WIDTH-1:1]};

`ifdef ZERO_BYPASS_EN
    assign bypass_d = (multiplicand == '0) || (multiplier == '0);
`else
    assign bypass_d = 1'b0;
`endif

    // The adder is only fed during RUN so its result is never consumed in other states.
    assign add_a = (state_q == RUN) ? a_q : '0;
    assign add_b = ((state_q == RUN) && q_q[0]) ? m_q : '0;

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (bypass_d) begin
                            product_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            m_q     <= multiplicand;
                            q_q     <= multiplier;
                            a_q     <= '0;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    {a_q, q_q} <= shift_d;
                    cnt_q      <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ITER) begin
                        product_q <= shift_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl with a behavioural 4-bit adder attached.
// Zero-operand latency expectations follow ZERO_BYPASS_EN.
module tb_shift_add_mult_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [3:0] addA;
    logic [3:0] addB;
    logic [3:0] addSum;
    logic       addCout;

    int total = 0;
    int bad   = 0;

    shift_add_mult_ctrl #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (addA),
        .add_b        (addB),
        .add_sum      (addSum),
        .add_cout     (addCout)
    );

    assign {addCout, addSum} = {1'b0, addA} + {1'b0, addB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ZERO_BYPASS_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 4;
`endif

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns one time unit after the accepting edge.
    task automatic applyStimulus(input logic [3:0] m, input logic [3:0] q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        step();
        start        = 1'b0;
        multiplicand = $urandom_range(0, 15);
        multiplier   = $urandom_range(0, 15);
    endtask

    task automatic waitDone(output int lat);
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            step();
        end
    endtask

    task automatic runMul(input string tag, input logic [3:0] m, input logic [3:0] q);
        int lat;
        int expLat;
        expLat = ((m == 4'd0) || (q == 4'd0)) ? ZERO_LAT : 4;
        applyStimulus(m, q);
        waitDone(lat);
        checkOutput({tag, "_lat"}, 16'(lat), 16'(expLat));
        checkOutput({tag, "_prod"}, {8'h00, product}, 16'(m * q));
        step();
        checkOutput({tag, "_idle"}, {14'd0, busy, done}, 16'h0000);
    endtask

    initial begin
        int lat;
        int pulses;
        int lastDone;
        int doneCount;

        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = 4'd0;
        multiplier   = 4'd0;
        repeat (2) step();
        checkOutput("rst_busy", {15'd0, busy}, 16'h0000);
        checkOutput("rst_done", {15'd0, done}, 16'h0000);
        checkOutput("rst_prod", {8'h00, product}, 16'h0000);
        checkOutput("rst_addab", {8'h00, addA, addB}, 16'h0000);
        rst_n = 1'b1;
        step();

        // 7*5: first iteration adds M, second skips it with A=3 after the shift.
        applyStimulus(4'd7, 4'd5);
        checkOutput("t1_busy", {15'd0, busy}, 16'h0001);
        checkOutput("t1_add0", {8'h00, addA, addB}, 16'h0007);
        step();
        checkOutput("t1_add1", {8'h00, addA, addB}, 16'h0030);
        checkOutput("t1_prodrun", {8'h00, product}, 16'h0000);
        waitDone(lat);
        checkOutput("t1_lat", 16'(lat + 1), 16'h0004);
        checkOutput("t1_prod", {8'h00, product}, 16'h0023);
        checkOutput("t1_addDone", {8'h00, addA, addB}, 16'h0000);
        repeat (3) step();
        checkOutput("t1_hold", {8'h00, product}, 16'h0023);
        checkOutput("t1_idle", {14'd0, busy, done}, 16'h0000);

        runMul("t2_ff", 4'd15, 4'd15);
        runMul("t2_11", 4'd1, 4'd1);
        runMul("t3_m0", 4'd0, 4'd9);
        runMul("t3_q0", 4'd9, 4'd0);

        // Extra starts during RUN and DONE must not launch a second job.
        applyStimulus(4'd3, 4'd3);
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            start        = (i == 1 || i == 2 || i == 4 || i == 5);
            multiplicand = 4'd2;
            multiplier   = 4'd2;
            step();
            if (done) pulses++;
        end
        start = 1'b0;
        checkOutput("t4_pulses", 16'(pulses), 16'h0001);
        checkOutput("t4_prod", {8'h00, product}, 16'h0009);
        checkOutput("t4_busy", {15'd0, busy}, 16'h0000);

        // Reset in the third RUN cycle aborts silently.
        applyStimulus(4'd6, 4'd7);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst", {6'd0, busy, done, product}, 16'h0000);
        step();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done || busy) pulses++;
        end
        checkOutput("t5_quiet", 16'(pulses), 16'h0000);
        runMul("t5_re", 4'd6, 4'd7);

        start        = 1'b1;
        multiplicand = 4'd5;
        multiplier   = 4'd3;
        lastDone     = -1;
        doneCount    = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                doneCount++;
                checkOutput("t6_prod", {8'h00, product}, 16'h000F);
                if (lastDone >= 0) checkOutput("t6_period", 16'(i - lastDone), 16'h0006);
                lastDone = i;
            end
        end
        start = 1'b0;
        checkOutput("t6_count", 16'(doneCount), 16'h0003);
        repeat (8) step();

        for (int m = 0; m < 16; m++) begin
            for (int q = 0; q < 16; q++) begin
                runMul("sweep", 4'(m), 4'(q));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
